// File: rtl/ir_frame_receiver_pkg.sv
// Shared types and timing-window helpers for the pulse-distance IR frame receiver.
package ir_pkg;

   typedef enum logic [1:0] {IDLE, LEADER, DATA, CHECK} state_t;

   typedef enum logic [2:0] {CLS_T0, CLS_T1, CLS_START, CLS_REPEAT, CLS_INVALID} cls_t;

   // Inclusive acceptance window around a nominal interval.
   function automatic int unsigned win_lo(input int unsigned nominal, input int unsigned tol_shift);
      return nominal - (nominal >> tol_shift);
   endfunction

   function automatic int unsigned win_hi(input int unsigned nominal, input int unsigned tol_shift);
      return nominal + (nominal >> tol_shift);
   endfunction

   function automatic bit win_overlap(input int unsigned a, input int unsigned b,
                                      input int unsigned tol_shift);
      return (win_lo(a, tol_shift) <= win_hi(b, tol_shift)) &&
             (win_lo(b, tol_shift) <= win_hi(a, tol_shift));
   endfunction

endpackage

// File: rtl/ir_frame_receiver_if.sv
// Consumer-side bus of the IR receiver: decoded frame, status pulses and ready/ack handshake.
interface ir_frame_receiver_if #(parameter int NBITS = 32);

   logic             ack;
   logic [NBITS-1:0] command;
   logic             ready;
   logic             repeat_pulse;
   logic [7:0]       repeat_count;
   logic             error;
   logic             overrun;

   modport master (input ack, output command, ready, repeat_pulse, repeat_count, error, overrun);
   modport slave  (output ack, input command, ready, repeat_pulse, repeat_count, error, overrun);

endinterface

// File: rtl/ir_frame_receiver_input_filter.sv
// Two-flop synchroniser plus persistence filter for an idle-high input; emits a
// one-cycle pulse when the filtered level falls.
module ir_input_filter #(
   parameter int FILTER_LEN = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Synchronise, then accept a new level only after it persisted FILTER_LEN cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         fall  <= 1'b0;
         if (sync2 != level) begin
            if (cnt == CW'(FILTER_LEN - 1)) begin
               level <= sync2;
               cnt   <= '0;
               fall  <= ~sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ir_frame_receiver.sv
// Pulse-distance IR frame receiver: classifies falling-edge intervals, assembles
// LSB-first frames, detects repeat codes and hands frames over with ready/ack.
module ir_frame_receiver import ir_pkg::*; #(
   parameter int NBITS      = 32,
   parameter int T0         = 28750,
   parameter int T1         = 56250,
   parameter int START      = 126250,
   parameter int REPEAT     = 281250,
   parameter int TOL_SHIFT  = 3,
   parameter int TIMEOUT    = 350000,
   parameter int FILTER_LEN = 16,
   parameter int CHECK_INV  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                ir_input,
   output logic                test,
   ir_frame_receiver_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int BC_W  = $clog2(NBITS);

   localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LO_T0    = CNT_W'(win_lo(T0, TOL_SHIFT));
   localparam logic [CNT_W-1:0] HI_T0    = CNT_W'(win_hi(T0, TOL_SHIFT));
   localparam logic [CNT_W-1:0] LO_T1    = CNT_W'(win_lo(T1, TOL_SHIFT));
   localparam logic [CNT_W-1:0] HI_T1    = CNT_W'(win_hi(T1, TOL_SHIFT));
   localparam logic [CNT_W-1:0] LO_START = CNT_W'(win_lo(START, TOL_SHIFT));
   localparam logic [CNT_W-1:0] HI_START = CNT_W'(win_hi(START, TOL_SHIFT));
   localparam logic [CNT_W-1:0] LO_REP   = CNT_W'(win_lo(REPEAT, TOL_SHIFT));
   localparam logic [CNT_W-1:0] HI_REP   = CNT_W'(win_hi(REPEAT, TOL_SHIFT));
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(NBITS - 1);

   if (NBITS < 8 || NBITS > 32) begin : g_bad_nbits
      $error("ir_frame_receiver: NBITS must be within 8..32");
   end
   if (win_overlap(T0, T1, TOL_SHIFT) || win_overlap(T0, START, TOL_SHIFT) ||
       win_overlap(T0, REPEAT, TOL_SHIFT) || win_overlap(T1, START, TOL_SHIFT) ||
       win_overlap(T1, REPEAT, TOL_SHIFT) || win_overlap(START, REPEAT, TOL_SHIFT)) begin : g_overlap
      $error("ir_frame_receiver: interval windows overlap");
   end
   if (TIMEOUT <= int'(win_hi(START, TOL_SHIFT)) || TIMEOUT <= int'(win_hi(REPEAT, TOL_SHIFT)) ||
       TIMEOUT <= int'(win_hi(T1, TOL_SHIFT))) begin : g_timeout
      $error("ir_frame_receiver: TIMEOUT must exceed every window upper bound");
   end

   logic             level;
   logic             fall;
   logic [CNT_W-1:0] ivl;
   cls_t             cls;
   state_t           state;
   state_t           state_d;
   logic [BC_W-1:0]  bitcnt;
   logic [NBITS-1:0] data_sr;
   logic             last_valid;
   logic             inv_ok;
   logic             clr_bits;
   logic             shift_en;
   logic             bit_val;
   logic             frame_ok;
   logic             err_now;
   logic             rep_acc;

   ir_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (ir_input),
      .level (level),
      .fall  (fall)
   );

   assign test = level;

   if (CHECK_INV != 0 && NBITS == 32) begin : g_inv
      assign inv_ok = (data_sr[31:24] == ~data_sr[23:16]);
   end else begin : g_no_inv
      assign inv_ok = 1'b1;
   end

   // Cycles since the last filtered falling edge, saturating at TIMEOUT.
   always_ff @(posedge clk) begin
      if (!rst)              ivl <= TMO;
      else if (fall)         ivl <= CNT_W'(1);
      else if (ivl != TMO)   ivl <= ivl + 1'b1;
   end

   // Map the interval ending at this edge to a symbol, highest priority first.
   always_comb begin
      cls = CLS_INVALID;
      if (ivl >= LO_START && ivl <= HI_START)  cls = CLS_START;
      else if (ivl >= LO_REP && ivl <= HI_REP) cls = CLS_REPEAT;
      else if (ivl >= LO_T1 && ivl <= HI_T1)   cls = CLS_T1;
      else if (ivl >= LO_T0 && ivl <= HI_T0)   cls = CLS_T0;
   end

   // Frame FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   // Next-state and per-cycle decode actions.
   always_comb begin
      state_d  = state;
      clr_bits = 1'b0;
      shift_en = 1'b0;
      bit_val  = 1'b0;
      frame_ok = 1'b0;
      err_now  = 1'b0;
      rep_acc  = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE: if (fall) state_d = LEADER;
            LEADER: begin
               if (fall) begin
                  if (cls == CLS_START) begin
                     state_d  = DATA;
                     clr_bits = 1'b1;
                  end else if (cls == CLS_REPEAT) begin
                     state_d = IDLE;
                     rep_acc = last_valid;
                  end
               end else if (ivl == TMO) begin
                  state_d = IDLE;
               end
            end
            DATA: begin
               if (fall) begin
                  if (cls == CLS_T0 || cls == CLS_T1) begin
                     shift_en = 1'b1;
                     bit_val  = (cls == CLS_T1);
                     if (bitcnt == LAST_BIT) state_d = CHECK;
                  end else begin
                     err_now = 1'b1;
                     state_d = IDLE;
                  end
               end else if (ivl == TMO) begin
                  err_now = 1'b1;
                  state_d = IDLE;
               end
            end
            CHECK: begin
               state_d  = IDLE;
               frame_ok = inv_ok;
               err_now  = ~inv_ok;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Bit assembly and memory of whether the last frame was good (gates repeats).
   always_ff @(posedge clk) begin
      if (!rst) begin
         bitcnt     <= '0;
         data_sr    <= '0;
         last_valid <= 1'b0;
      end else begin
         if (clr_bits) begin
            bitcnt <= '0;
         end else if (shift_en) begin
            data_sr[bitcnt] <= bit_val;
            bitcnt          <= bitcnt + 1'b1;
         end
         if (frame_ok)     last_valid <= 1'b1;
         else if (err_now) last_valid <= 1'b0;
      end
   end

   // Consumer-facing outputs: frame latch, ready/ack handshake, overrun and repeat tracking.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.command      <= '0;
         bus.ready        <= 1'b0;
         bus.overrun      <= 1'b0;
         bus.repeat_pulse <= 1'b0;
         bus.repeat_count <= '0;
         bus.error        <= 1'b0;
      end else begin
         bus.error        <= err_now;
         bus.repeat_pulse <= rep_acc;
         if (rep_acc && bus.repeat_count != 8'hFF) bus.repeat_count <= bus.repeat_count + 1'b1;
         if (frame_ok) begin
            bus.command      <= data_sr;
            bus.ready        <= 1'b1;
            bus.repeat_count <= '0;
            if (bus.ready && !bus.ack) bus.overrun <= 1'b1;
         end else if (bus.ack && bus.ready) begin
            bus.ready   <= 1'b0;
            bus.overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ir_frame_receiver.sv
// Directed bench for ir_frame_receiver: waveform generator for pulse-distance frames,
// expected-command queue and pulse counters.
module tb_ir_frame_receiver;

   localparam int NBITS      = 32;
   localparam int T0         = 20;
   localparam int T1         = 40;
   localparam int START      = 120;
   localparam int REPEAT     = 80;
   localparam int TOL_SHIFT  = 3;
   localparam int TIMEOUT    = 200;
   localparam int FILTER_LEN = 2;
   localparam int CHECK_INV  = 1;
   localparam int GAP        = 250;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b1;
   logic ir_input = 1'b1;
   logic test;

   ir_frame_receiver_if #(.NBITS(NBITS)) bus ();

   ir_frame_receiver #(
      .NBITS(NBITS), .T0(T0), .T1(T1), .START(START), .REPEAT(REPEAT),
      .TOL_SHIFT(TOL_SHIFT), .TIMEOUT(TIMEOUT), .FILTER_LEN(FILTER_LEN), .CHECK_INV(CHECK_INV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .ir_input (ir_input),
      .test     (test),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int err_pulses = 0;
   int rep_pulses = 0;
   int e0;
   int r0;
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      if (rst) begin
         if (bus.error)        err_pulses++;
         if (bus.repeat_pulse) rep_pulses++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One falling edge on the pin, then hold until the next edge is due ivl cycles later.
   task automatic send_edge(input int ivl, input bit glitch);
      ir_input = 1'b0;
      if (glitch) begin
         repeat (3) @(negedge clk);
         ir_input = 1'b1;
         @(negedge clk);
         ir_input = 1'b0;
         repeat (4) @(negedge clk);
         ir_input = 1'b1;
         repeat (3) @(negedge clk);
         ir_input = 1'b0;
         @(negedge clk);
         ir_input = 1'b1;
         repeat (ivl - 12) @(negedge clk);
      end else begin
         repeat (8) @(negedge clk);
         ir_input = 1'b1;
         repeat (ivl - 8) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [31:0] d, input int jit, input int bad_bit,
                             input bit glitch, input int nbits_sent);
      int sgn;
      int ivl;
      sgn = 1;
      send_edge(START + jit * sgn, glitch);
      for (int i = 0; i < nbits_sent; i++) begin
         sgn = -sgn;
         ivl = (d[i] ? T1 : T0) + jit * sgn;
         if (i == bad_bit) ivl = 30;
         send_edge(ivl, glitch);
      end
      if (nbits_sent == NBITS) send_edge(GAP, glitch);
   endtask

   task automatic send_repeat();
      send_edge(REPEAT, 1'b0);
      send_edge(GAP, 1'b0);
   endtask

   task automatic check_frame(input string tag);
      logic [31:0] e;
      chk({tag, ".queued"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, ".command"}, 64'(bus.command), 64'(e));
         chk({tag, ".ready"}, 64'(bus.ready), 64'd1);
      end
   endtask

   task automatic do_ack();
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      chk("ack.ready", 64'(bus.ready), 64'd0);
      chk("ack.overrun", 64'(bus.overrun), 64'd0);
   endtask

   initial begin
      bus.ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.command", 64'(bus.command), 64'd0);
      chk("rst.ready", 64'(bus.ready), 64'd0);
      chk("rst.overrun", 64'(bus.overrun), 64'd0);
      chk("rst.repeat_count", 64'(bus.repeat_count), 64'd0);
      chk("rst.error", 64'(bus.error), 64'd0);
      chk("rst.test", 64'(test), 64'd1);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Nominal frame, held without ack.
      e0 = err_pulses;
      exp_q.push_back(32'hE11E_00FF);
      send_frame(32'hE11E_00FF, 0, -1, 1'b0, NBITS);
      check_frame("nominal");
      chk("nominal.err", 64'(err_pulses - e0), 64'd0);
      chk("nominal.overrun", 64'(bus.overrun), 64'd0);
      do_ack();

      // Every interval jittered by +/-2 cycles.
      e0 = err_pulses;
      exp_q.push_back(32'hE11E_00FF);
      send_frame(32'hE11E_00FF, 2, -1, 1'b0, NBITS);
      check_frame("jitter");
      chk("jitter.err", 64'(err_pulses - e0), 64'd0);

      // Out-of-window bit interval: one error, ready and command untouched.
      e0 = err_pulses;
      send_frame(32'hE11E_00FF, 0, 5, 1'b0, NBITS);
      chk("badbit.err", 64'(err_pulses - e0), 64'd1);
      chk("badbit.ready", 64'(bus.ready), 64'd1);
      chk("badbit.command", 64'(bus.command), 64'hE11E_00FF);
      do_ack();

      // Inverse-byte failure, then a repeat that must be ignored.
      e0 = err_pulses;
      send_frame(32'h001E_00FF, 0, -1, 1'b0, NBITS);
      chk("inv.err", 64'(err_pulses - e0), 64'd1);
      chk("inv.command", 64'(bus.command), 64'hE11E_00FF);
      chk("inv.ready", 64'(bus.ready), 64'd0);
      r0 = rep_pulses;
      send_repeat();
      chk("inv.repeat_pulses", 64'(rep_pulses - r0), 64'd0);
      chk("inv.repeat_count", 64'(bus.repeat_count), 64'd0);

      // Valid frame followed by three repeat codes.
      exp_q.push_back(32'h12ED_A55A);
      send_frame(32'h12ED_A55A, 0, -1, 1'b0, NBITS);
      check_frame("rep_base");
      do_ack();
      r0 = rep_pulses;
      send_repeat();
      send_repeat();
      send_repeat();
      chk("rep.pulses", 64'(rep_pulses - r0), 64'd3);
      chk("rep.count", 64'(bus.repeat_count), 64'd3);
      exp_q.push_back(32'h7F80_1234);
      send_frame(32'h7F80_1234, 0, -1, 1'b0, NBITS);
      check_frame("rep_new");
      chk("rep_new.count", 64'(bus.repeat_count), 64'd0);

      // Second frame without ack overwrites and flags overrun.
      exp_q.push_back(32'h00FF_FFFF);
      send_frame(32'h00FF_FFFF, 0, -1, 1'b0, NBITS);
      check_frame("overrun");
      chk("overrun.flag", 64'(bus.overrun), 64'd1);
      do_ack();

      // Single-cycle glitches on the pin in both phases.
      e0 = err_pulses;
      exp_q.push_back(32'hA55A_0F0F);
      send_frame(32'hA55A_0F0F, 0, -1, 1'b1, NBITS);
      check_frame("glitch");
      chk("glitch.err", 64'(err_pulses - e0), 64'd0);

      // Reset in the middle of a frame, then a full frame.
      send_frame(32'h3CC3_5A5A, 0, -1, 1'b0, 10);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst.command", 64'(bus.command), 64'd0);
      chk("midrst.ready", 64'(bus.ready), 64'd0);
      chk("midrst.overrun", 64'(bus.overrun), 64'd0);
      chk("midrst.test", 64'(test), 64'd1);
      rst = 1'b1;
      repeat (GAP) @(negedge clk);
      e0 = err_pulses;
      exp_q.push_back(32'h01FE_C3C3);
      send_frame(32'h01FE_C3C3, 0, -1, 1'b0, NBITS);
      check_frame("after_rst");
      chk("after_rst.err", 64'(err_pulses - e0), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
